// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

    localparam int N_DEF    = 8;
    localparam int NREG_DEF = 16;

    function automatic int aw(input int nreg);
        return $clog2(nreg);
    endfunction

    typedef logic [NREG_DEF-1:0] busy_t;

endpackage

// File: rtl/regfile_sb_decodificador.sv
// Binary address to one-hot select decoder.
module regfile_sb_decodificador #(
    parameter int AW   = 4,
    parameter int NREG = 16
) (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] oh
);

    always_comb begin
        oh       = '0;
        oh[addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file: 1 write / 2 async read ports, hardwired R0, write bypass and busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NREG    = NREG_DEF,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1,
    localparam int AW     = aw(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we3,
    input  logic [AW-1:0] wa3,
    input  logic [N-1:0]  wd3,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    input  logic          iss,
    input  logic [AW-1:0] iss_wa,
    output logic          haz1,
    output logic          haz2,
    output logic [AW:0]   busy_cnt
);

    logic [N-1:0]    regs_q [NREG];
    logic [N-1:0]    regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     busy_cnt_q, busy_cnt_d;
    logic [NREG-1:0] wr_oh, iss_oh;
    logic            wr_ok;

    function automatic logic [AW:0] count_ones(input logic [NREG-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + (AW+1)'(v[i]);
        end
        return cnt;
    endfunction

    regfile_sb_decodificador #(.AW(AW), .NREG(NREG)) u_dec_wr (
        .addr (wa3),
        .oh   (wr_oh)
    );

    regfile_sb_decodificador #(.AW(AW), .NREG(NREG)) u_dec_iss (
        .addr (iss_wa),
        .oh   (iss_oh)
    );

    // Writes aimed at a hardwired R0 are discarded before they reach storage or bypass.
    assign wr_ok = we3 && !(ZERO_R0 && (wa3 == '0));

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
            busy_d = '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_ok && wr_oh[i]) begin
                    regs_d[i] = wd3;
                end
            end
            // Set is applied after clear so a same-cycle reissue keeps the register busy.
            busy_d = (busy_q & ~(we3 ? wr_oh : '0)) | (iss ? iss_oh : '0);
            if (ZERO_R0) begin
                busy_d[0] = 1'b0;
            end
        end
        busy_cnt_d = count_ones(busy_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        rd1 = regs_q[ra1];
        if (ZERO_R0 && (ra1 == '0)) begin
            rd1 = '0;
        end else if (BYPASS && wr_ok && (wa3 == ra1)) begin
            rd1 = wd3;
        end
    end

    always_comb begin
        rd2 = regs_q[ra2];
        if (ZERO_R0 && (ra2 == '0)) begin
            rd2 = '0;
        end else if (BYPASS && wr_ok && (wa3 == ra2)) begin
            rd2 = wd3;
        end
    end

    assign haz1     = busy_q[ra1] && !(BYPASS && we3 && (wa3 == ra1));
    assign haz2     = busy_q[ra2] && !(BYPASS && we3 && (wa3 == ra2));
    assign busy_cnt = busy_cnt_q;

endmodule
